msrv32_prefetch_buffer: RTL

Parametrised instruction prefetch buffer between the MSRV32 core's fetch stage and its AHB-Lite-style instruction bus. It replaces the single-word, stall-on-`hready` fetch with pipelined address/data phases and a DEPTH-entry FIFO of fetched words. Each word carries its PC and a bus-error flag. The core consumes words through a valid/ready handshake and redirects fetch on branch, jump, trap or `mret`.

---
 rtl/msrv32_prefetch_buffer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/msrv32_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// msrv32_prefetch_buffer
//
// Instruction prefetch buffer between the MSRV32 fetch stage and an
// AHB-Lite-style instruction bus.  Address and data phases are pipelined,
// with at most one data phase outstanding.  Fetched words are queued in a
// DEPTH-entry FIFO together with their PC and a bus-error flag.  The core
// drains the FIFO through a valid/ready handshake and can redirect fetch at
// any time (branch, jump, trap, mret).
//
// Optional feature macro: MSRV32_PF_BYPASS_EN
//   Defined   : when the FIFO is empty, a completing data phase is forwarded
//               combinationally to the head outputs (1-cycle fetch latency).
//   Undefined : head outputs come straight from FIFO storage (2-cycle latency).
//
// Ports
//   clk_in, rst_in                 clock, asynchronous active-low reset
//   imaddr_out, ireq_out           bus address phase (address is registered)
//   instr_in, instr_hready_in,
//   instr_hresp_in                 bus data phase / ready / error
//   redirect_in, redirect_addr_in  flush and restart fetch at a new address
//   instr_out, pc_out, err_out,
//   valid_out, ready_in            head-entry handshake towards the core
//   count_out                      number of occupied FIFO entries
// -----------------------------------------------------------------------------
module msrv32_prefetch_buffer #(
    parameter int          DEPTH        = 4,
    parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    output logic [31:0]                imaddr_out,
    output logic                       ireq_out,
    input  logic [31:0]                instr_in,
    input  logic                       instr_hready_in,
    input  logic                       instr_hresp_in,
    input  logic                       redirect_in,
    input  logic [31:0]                redirect_addr_in,
    output logic [31:0]                instr_out,
    output logic [31:0]                pc_out,
    output logic                       err_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH+1)-1:0] count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   addr_q, addr_d;
    logic [31:0]   pend_pc_q, pend_pc_d;    // PC of the outstanding data phase
    logic          rst_hold_q;
    logic          halted_q, halted_d;
    logic          inflight_q, inflight_d;
    logic          discard_q, discard_d;    // outstanding data must be dropped
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];
    logic          mem_err_q   [DEPTH];

    logic          credit_ok;
    logic          accept;
    logic          dphase;
    logic          push;
    logic          wr_en;
    logic          pop_fifo;
    logic          fifo_valid;
    logic [31:0]   push_instr;
`ifdef MSRV32_PF_BYPASS_EN
    logic          bypass_hit;
`endif

    // ---------------------------------------------------------------- control
    always_comb begin
        // Queued entries plus the word still on the bus must fit, so a push is
        // never refused.
        credit_ok  = (32'(count_q) + 32'(inflight_q)) < 32'(DEPTH);
        // While a dropped data phase is still on the bus, hold off new requests
        // so the first word after a redirect is the redirect target.
        ireq_out   = !rst_hold_q && !halted_q && !discard_q && !redirect_in && credit_ok;
        accept     = ireq_out && instr_hready_in;
        dphase     = inflight_q && instr_hready_in;
        push       = dphase && !discard_q && !redirect_in;
        push_instr = instr_hresp_in ? 32'h0 : instr_in;
        fifo_valid = (count_q != '0);
        pop_fifo   = fifo_valid && ready_in && !redirect_in;
`ifdef MSRV32_PF_BYPASS_EN
        bypass_hit = push && !fifo_valid;
        // A forwarded word the core takes immediately never enters storage.
        wr_en      = push && !(bypass_hit && ready_in);
        valid_out  = fifo_valid || bypass_hit;
        instr_out  = bypass_hit ? push_instr     : mem_instr_q[rd_ptr_q];
        pc_out     = bypass_hit ? pend_pc_q      : mem_pc_q[rd_ptr_q];
        err_out    = bypass_hit ? instr_hresp_in : mem_err_q[rd_ptr_q];
`else
        wr_en      = push;
        valid_out  = fifo_valid;
        instr_out  = mem_instr_q[rd_ptr_q];
        pc_out     = mem_pc_q[rd_ptr_q];
        err_out    = mem_err_q[rd_ptr_q];
`endif
        imaddr_out = addr_q;
        count_out  = count_q;
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        addr_d     = addr_q;
        pend_pc_d  = pend_pc_q;
        halted_d   = halted_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (accept) begin
            addr_d    = addr_q + 32'd4;
            pend_pc_d = addr_q;
        end

        if (accept) begin
            inflight_d = 1'b1;
        end else if (dphase) begin
            inflight_d = 1'b0;
        end

        if (redirect_in) begin
            addr_d    = {redirect_addr_in[31:2], 2'b00};
            halted_d  = 1'b0;
            // A data phase completing in this very cycle is simply not pushed;
            // one still waiting on hready must be dropped when it arrives.
            discard_d = inflight_q && !instr_hready_in;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (dphase) begin
                // An address accepted alongside an errored data phase belongs
                // to the abandoned stream and is dropped.
                discard_d = push && instr_hresp_in && accept;
            end
            if (push && instr_hresp_in) begin
                halted_d = 1'b1;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_fifo) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(pop_fifo);
        end
    end

    // -------------------------------------------------------------- registers
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_q     <= BOOT_ADDRESS;
            pend_pc_q  <= '0;
            rst_hold_q <= 1'b1;
            halted_q   <= 1'b0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            pend_pc_q  <= pend_pc_d;
            rst_hold_q <= 1'b0;
            halted_q   <= halted_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage is reset so the head outputs read zero out of reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= '0;
                mem_pc_q[i]    <= '0;
                mem_err_q[i]   <= 1'b0;
            end
        end else if (wr_en) begin
            mem_instr_q[wr_ptr_q] <= push_instr;
            mem_pc_q[wr_ptr_q]    <= pend_pc_q;
            mem_err_q[wr_ptr_q]   <= instr_hresp_in;
        end
    end

endmodule
